iter_muldiv: RTL
================

Name: iter_muldiv

Overview:
Multicycle multiply/divide unit sitting beside the single-cycle ALU in the ARM datapath. Executes MUL, UMULL, SMULL, UDIV and SDIV iteratively, one bit per cycle, using a start/busy/done handshake. The controller stalls PC and register write until done. Width is parametrised; flags use the ALU's {N,Z,C,V} ordering.

Parameters:
WIDTH, 32, operand and result-half width in bits (must be ≥4 and even).
CNTW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request; sampled only when busy=0
abort  input  1  synchronous cancel of an in-flight operation
op  input  3  000 MUL, 001 UMULL, 010 SMULL, 011 UDIV, 100 SDIV; others illegal
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; results valid on this cycle and held afterwards
result_lo  output  WIDTH  product low half / quotient
result_hi  output  WIDTH  product high half (0 for MUL) / remainder
flags  output  4  {N,Z,C,V}

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, done=0, result_lo=0, result_hi=0, flags=0; counter and internal registers cleared. Reset asserted mid-operation discards the operation with no done pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE: when start=1, latch op, a and b. Signed ops capture operand signs and take absolute values. Go to RUN with count=0. Illegal op: go to DONE with results 0 and flags 0.
- RUN: one shift-add step (multiply) or restoring shift-subtract step (divide) per cycle, for exactly WIDTH cycles. Multiply accumulator is 2*WIDTH bits. Divide keeps a WIDTH+1-bit partial remainder. Then go to FIX.
- FIX, one cycle: apply sign correction. Product is negated if the operand signs differ. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend (truncation toward zero). Compute flags. Go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE. A start presented in the DONE cycle is ignored.
- Latency: start sampled at edge k gives done=1 during cycle k+WIDTH+2. Outputs are registered.
- Divide by zero (b==0, UDIV or SDIV): bypass RUN and go IDLE→DONE. Quotient=0, remainder=a, C=1; done in cycle k+1.
- SDIV overflow (a=most negative, b=-1): quotient=most negative, remainder=0, V=1, normal latency.
- N: MSB of result_hi for UMULL/SMULL, MSB of result_lo otherwise.
- Z: {hi,lo}==0 for long multiply, lo==0 otherwise.
- C is set only on divide by zero; V is set only on SDIV overflow. C and V are 0 for all multiplies.
- start while busy=1: ignored, no queueing.
- abort=1 while busy: return to IDLE next edge; no done; outputs keep their previous values. abort in IDLE is ignored. abort and start in the same IDLE cycle: start wins.
- result_lo, result_hi and flags update only in the FIX or DONE transitions.

Optional Feature:
MULDIV_SIGNED_EN.
- Defined: SMULL and SDIV perform signed arithmetic as specified above.
- Undefined: the sign-capture and negation logic is removed; SMULL behaves exactly as UMULL and SDIV exactly as UDIV (V is never set). Latency is unchanged.

Decomposition:
- Package muldiv_pkg holds:
  - op_t enum (MUL, UMULL, SMULL, UDIV, SDIV)
  - state_t enum (IDLE, RUN, FIX, DONE)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module muldiv_step (combinational, parametrised by WIDTH): one iteration, either a conditional add plus right shift or a trial subtract plus left shift, selected by a mode bit. The top-level keeps the FSM, counter, sign handling and output registers.

Test Plan:
- MUL a=7 b=6 → result_lo=42, result_hi=0, flags=0000; done exactly 34 cycles after start is accepted; busy high for cycles 1–33.
- UMULL a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, N=1. SMULL a=-3 b=5 → {hi,lo}=-15 (hi=0xFFFFFFFF, lo=0xFFFFFFF1), N=1.
- UDIV 100/7 → q=14, r=2. SDIV -7/2 → q=0xFFFFFFFD, r=0xFFFFFFFF, N=1. SDIV 0x80000000/0xFFFFFFFF → q=0x80000000, r=0, V=1.
- UDIV 5/0 → q=0, r=5, C=1, done 1 cycle after acceptance. A start pulse during busy of a 100/7 divide → ignored, single done with q=14.
- abort at RUN cycle 10 → busy=0 next cycle, no done, prior results held. reset=0 at RUN cycle 5 → all outputs 0 immediately, no done.
- With MULDIV_SIGNED_EN undefined: SDIV 0xFFFFFFF9/2 → q=0x7FFFFFFC, r=1, V=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
//   op_t    : operation encoding carried on the 3-bit op input
//   state_t : controller states
//   FLAG_*  : bit positions inside the {N,Z,C,V} flags vector (same order as the ALU)
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul   = 3'd0,
    OpUmull = 3'd1,
    OpSmull = 3'd2,
    OpUdiv  = 3'd3,
    OpSdiv  = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/response bundle between the datapath controller and iter_muldiv.
//   start, abort, op, a, b             : request side (driven by master)
//   busy, done, result_lo/hi, flags    : response side (driven by slave)
interface iter_muldiv_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic             abort;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       flags;

  modport master (
    output start, abort, op, a, b,
    input  busy, done, result_lo, result_hi, flags
  );

  modport slave (
    input  start, abort, op, a, b,
    output busy, done, result_lo, result_hi, flags
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   mode=0 : shift-add multiply. acc = {partial product, remaining multiplier};
//            add opnd to the upper half if acc[0], then shift right by one.
//   mode=1 : restoring divide. acc[WIDTH-1:0] holds dividend bits (MSB first out)
//            and collects quotient bits at the LSB; rem is the partial remainder.
// Ports: mode, acc_in, rem_in, opnd (multiplicand / divisor) -> acc_out, rem_out.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 mode,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH:0]       rem_in,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_out,
  output logic [WIDTH:0]       rem_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  // Partial remainder is always below the divisor, so its top bit stays clear.
  logic           unused_rem_msb;

  assign unused_rem_msb = rem_in[WIDTH];

  always_comb begin
    acc_out = acc_in;
    rem_out = rem_in;
    sum     = '0;
    shifted = '0;
    trial   = '0;
    if (!mode) begin
      sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end else begin
      shifted = {rem_in[WIDTH-1:0], acc_in[WIDTH-1]};
      trial   = shifted - {1'b0, opnd};
      // A borrow shows up as the top bit of the trial difference.
      if (!trial[WIDTH]) begin
        rem_out = trial;
        acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        rem_out = shifted;
        acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit: MUL, UMULL, SMULL, UDIV, SDIV, one bit per cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : iter_muldiv_if.slave (start/abort/op/a/b in; busy/done/results/flags out)
// Build option: define MULDIV_SIGNED_EN for signed SMULL/SDIV; without it they behave
// as UMULL/UDIV with identical latency.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  iter_muldiv_if.slave bus
);

  localparam int unsigned     CNTW     = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q;
  op_t                op_q;
  logic [CNTW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_res_q, neg_rem_q, ovf_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [3:0]         flags_q;

  logic               op_legal, op_is_div, signed_op, a_neg, b_neg, ovf_in;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               run_div;
  logic [2*WIDTH-1:0] step_acc, prod;
  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   quo, rem, fix_lo, fix_hi;
  logic [3:0]         fix_flags, dz_flags;

  // Request decode and operand conditioning for the IDLE capture.
  always_comb begin
    op_legal  = bus.op <= OpSdiv;
    op_is_div = (bus.op == OpUdiv) || (bus.op == OpSdiv);
    signed_op = 1'b0;
`ifdef MULDIV_SIGNED_EN
    signed_op = (bus.op == OpSmull) || (bus.op == OpSdiv);
`endif
    a_neg  = signed_op & bus.a[WIDTH-1];
    b_neg  = signed_op & bus.b[WIDTH-1];
    a_abs  = a_neg ? -bus.a : bus.a;
    b_abs  = b_neg ? -bus.b : bus.b;
    // MOST_NEG / -1 still runs normally; magnitudes give the wrapped quotient.
    ovf_in = signed_op && op_is_div && (bus.a == MOST_NEG) && (bus.b == '1);
    dz_flags         = '0;
    dz_flags[FLAG_Z] = 1'b1;
    dz_flags[FLAG_C] = 1'b1;
  end

  assign run_div = (op_q == OpUdiv) || (op_q == OpSdiv);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode    (run_div),
    .acc_in  (acc_q),
    .rem_in  (rem_q),
    .opnd    (opnd_q),
    .acc_out (step_acc),
    .rem_out (step_rem)
  );

  // Sign correction and flag generation used on the FIX -> DONE transition.
  always_comb begin
    prod      = neg_res_q ? -acc_q : acc_q;
    quo       = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    fix_lo    = '0;
    fix_hi    = '0;
    fix_flags = '0;
    if (run_div) begin
      fix_lo            = quo;
      fix_hi            = rem;
      fix_flags[FLAG_N] = quo[WIDTH-1];
      fix_flags[FLAG_Z] = (quo == '0);
      fix_flags[FLAG_V] = ovf_q;
    end else if (op_q == OpMul) begin
      fix_lo            = prod[WIDTH-1:0];
      fix_flags[FLAG_N] = prod[WIDTH-1];
      fix_flags[FLAG_Z] = (prod[WIDTH-1:0] == '0);
    end else begin
      fix_lo            = prod[WIDTH-1:0];
      fix_hi            = prod[2*WIDTH-1:WIDTH];
      fix_flags[FLAG_N] = prod[2*WIDTH-1];
      fix_flags[FLAG_Z] = (prod == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      flags_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q      <= op_legal ? op_t'(bus.op) : OpMul;
            cnt_q     <= '0;
            acc_q     <= {{WIDTH{1'b0}}, a_abs};
            rem_q     <= '0;
            opnd_q    <= b_abs;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            ovf_q     <= ovf_in;
            if (!op_legal) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              lo_q    <= '0;
              hi_q    <= '0;
              flags_q <= '0;
            end else if (op_is_div && (bus.b == '0)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              lo_q    <= '0;
              hi_q    <= bus.a;
              flags_q <= dz_flags;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= step_acc;
            rem_q <= step_rem;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNTW'(WIDTH - 1)) begin
              state_q <= StFix;
            end
          end
        end
        StFix: begin
          busy_q <= 1'b0;
          if (bus.abort) begin
            state_q <= StIdle;
          end else begin
            state_q <= StDone;
            done_q  <= 1'b1;
            lo_q    <= fix_lo;
            hi_q    <= fix_hi;
            flags_q <= fix_flags;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.flags     = flags_q;

endmodule
